// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: built-in self-test initiator for the register-file memory.
// Writes a seed-derived pattern to every location, then reads it all back
// and compares. It does this twice, once with the true pattern and once
// with the inverted pattern. It reports pass/fail, the first failing
// address and phase, and a saturating mismatch count.
module mem_bist_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 4,
    parameter int RDW   = 8,
    parameter int CW    = 4
) (
    input  logic           i_sys_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [DW-1:0]  i_seed,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_pass,
    output logic [AW-1:0]  o_fail_addr,
    output logic           o_fail_phase,
    output logic [CW-1:0]  o_fail_cnt,
    output logic           o_mem_wr,
    output logic [AW-1:0]  o_mem_wr_addr,
    output logic [DW-1:0]  o_mem_wr_data,
    output logic           o_mem_rd,
    output logic [AW-1:0]  o_mem_rd_addr,
    input  logic [RDW-1:0] i_mem_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Sweep position and test context
    logic [AW-1:0]  addr_q;
    logic           phase_q;
    logic [DW-1:0]  seed_q;

    // One-stage delayed read address that lines up with the registered read data
    logic           cmp_valid_q;
    logic [AW-1:0]  cmp_addr_q;

    // Result registers
    logic [CW-1:0]  fail_cnt_q;
    logic [AW-1:0]  fail_addr_q;
    logic           fail_phase_q;
    logic           pass_q;

    // Last driven memory address/data, so the port holds steady between strobes
    logic [AW-1:0]  wr_addr_q;
    logic [DW-1:0]  wr_data_q;
    logic [AW-1:0]  rd_addr_q;

    logic           last_addr;
    logic [DW-1:0]  wr_pattern;
    logic [RDW-1:0] exp_rd_data;
    logic           mismatch;

    // Phase 0 writes (address XOR seed); phase 1 writes its complement.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a,
                                              input logic          ph,
                                              input logic [DW-1:0] s);
        logic [DW-1:0] p;
        p = DW'(a) ^ s;
        return ph ? ~p : p;
    endfunction

    assign last_addr   = (addr_q == AW'(DEPTH - 1));
    assign wr_pattern  = pattern(addr_q, phase_q, seed_q);
    // Zero-extension means any stray upper read bit also counts as a mismatch.
    assign exp_rd_data = RDW'(pattern(cmp_addr_q, phase_q, seed_q));
    assign mismatch    = cmp_valid_q && (i_mem_rd_data != exp_rd_data);

    // State register
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state is updated with <= so that every flop samples
            // pre-edge values; a blocking = here would create order-dependent races.
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_d  = state_q;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_mem_wr = 1'b0;
        o_mem_rd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_WRITE;
            end
            S_WRITE: begin
                o_busy   = 1'b1;
                o_mem_wr = 1'b1;
                if (last_addr) state_d = S_READ;
            end
            S_READ: begin
                o_busy   = 1'b1;
                o_mem_rd = 1'b1;
                if (last_addr) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy  = 1'b1;
                state_d = phase_q ? S_DONE : S_WRITE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep counters, compare pipeline and result capture
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            // NOTE: all of these are small control/result flops rather than a
            // memory array, so each one is cleared and a reset leaves no stale result.
            addr_q       <= '0;
            phase_q      <= 1'b0;
            seed_q       <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
            fail_cnt_q   <= '0;
            fail_addr_q  <= '0;
            fail_phase_q <= 1'b0;
            pass_q       <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_addr_q    <= '0;
        end else begin
            cmp_valid_q <= (state_q == S_READ);
            cmp_addr_q  <= addr_q;

            if (mismatch) begin
                if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CW'(1);
                // The count only stays at zero until the first mismatch, so it marks "first".
                if (fail_cnt_q == '0) begin
                    fail_addr_q  <= cmp_addr_q;
                    fail_phase_q <= phase_q;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        seed_q       <= i_seed;
                        phase_q      <= 1'b0;
                        addr_q       <= '0;
                        fail_cnt_q   <= '0;
                        fail_addr_q  <= '0;
                        fail_phase_q <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                S_WRITE: begin
                    wr_addr_q <= addr_q;
                    wr_data_q <= wr_pattern;
                    addr_q    <= last_addr ? '0 : addr_q + AW'(1);
                end
                S_READ: begin
                    rd_addr_q <= addr_q;
                    addr_q    <= last_addr ? '0 : addr_q + AW'(1);
                end
                S_DRAIN: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        addr_q  <= '0;
                    end
                end
                S_DONE: begin
                    pass_q <= (fail_cnt_q == '0);
                end
                default: ;
            endcase
        end
    end

    // Address/data follow the sweep while strobing and hold the last value otherwise.
    assign o_mem_wr_addr = (state_q == S_WRITE) ? addr_q     : wr_addr_q;
    assign o_mem_wr_data = (state_q == S_WRITE) ? wr_pattern : wr_data_q;
    assign o_mem_rd_addr = (state_q == S_READ)  ? addr_q     : rd_addr_q;

    // The verdict is live in the DONE cycle, then held in pass_q.
    assign o_pass       = (state_q == S_DONE) ? (fail_cnt_q == '0) : pass_q;
    assign o_fail_addr  = fail_addr_q;
    assign o_fail_phase = fail_phase_q;
    assign o_fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: scoreboard bench for mem_bist_ctrl. A behavioural memory
// with selectable faults answers the DUT. Stimulus pushes hand-computed
// expected results, and monitors pop them and compare as the DUT produces them.
module tb_mem_bist_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int RDW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start;
    logic [DW-1:0]  seed;
    logic           busy, done, pass, fail_phase, mem_wr, mem_rd;
    logic [AW-1:0]  fail_addr, mem_wr_addr, mem_rd_addr;
    logic [3:0]     fail_cnt;
    logic [DW-1:0]  mem_wr_data;
    logic [RDW-1:0] mem_rd_data;

    // Second instance with a 2-bit counter, fed all-ones read data
    logic           start2;
    logic [DW-1:0]  seed2;
    logic           busy2, done2, pass2, fail_phase2, mem_wr2, mem_rd2;
    logic [AW-1:0]  fail_addr2, mem_wr_addr2, mem_rd_addr2;
    logic [1:0]     fail_cnt2;
    logic [DW-1:0]  mem_wr_data2;
    logic [RDW-1:0] mem_rd_data2;

    mem_bist_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RDW(RDW), .CW(4)) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_start(start), .i_seed(seed),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail_addr(fail_addr),
        .o_fail_phase(fail_phase), .o_fail_cnt(fail_cnt),
        .o_mem_wr(mem_wr), .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
        .o_mem_rd(mem_rd), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data)
    );

    mem_bist_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RDW(RDW), .CW(2)) dut2 (
        .i_sys_clk(clk), .i_rst(rst), .i_start(start2), .i_seed(seed2),
        .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_fail_addr(fail_addr2),
        .o_fail_phase(fail_phase2), .o_fail_cnt(fail_cnt2),
        .o_mem_wr(mem_wr2), .o_mem_wr_addr(mem_wr_addr2), .o_mem_wr_data(mem_wr_data2),
        .o_mem_rd(mem_rd2), .o_mem_rd_addr(mem_rd_addr2), .i_mem_rd_data(mem_rd_data2)
    );

    assign mem_rd_data2 = 8'hFF;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: registered read; fault_mode 1 = addr 2 bit0 stuck-at-1, 2 = addr 0 bit7 set
    logic [DW-1:0] mem [0:15];
    int fault_mode = 0;

    function automatic logic [RDW-1:0] model_read(input logic [AW-1:0] a);
        logic [RDW-1:0] d;
        d = {4'h0, mem[a]};
        if (fault_mode == 1 && a == 4'd2) d[0] = 1'b1;
        if (fault_mode == 2 && a == 4'd0) d[7] = 1'b1;
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_wr) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd) mem_rd_data <= model_read(mem_rd_addr);
    end

    // Scoreboard queues
    typedef struct {
        int         cyc;
        logic       pass;
        logic [3:0] addr;
        logic       phase;
        logic [3:0] cnt;
    } exp_t;

    exp_t       done_q[$];
    exp_t       done_q2[$];
    logic [7:0] wr_q[$];     // {addr, data}
    exp_t       e1, e2;
    logic [7:0] ew;

    // Monitor for the main instance
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr || mem_rd) check("strobe_exclusive", {31'd0, mem_wr & mem_rd}, 32'd0);
            if (mem_wr && wr_q.size() > 0) begin
                ew = wr_q.pop_front();
                check("wr_addr", {28'd0, mem_wr_addr}, {28'd0, ew[7:4]});
                check("wr_data", {28'd0, mem_wr_data}, {28'd0, ew[3:0]});
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_expected", done_q.size(), 32'd1);
                end else begin
                    e1 = done_q.pop_front();
                    check("done_cycle",  cyc, e1.cyc);
                    check("pass",        {31'd0, pass}, {31'd0, e1.pass});
                    check("fail_addr",   {28'd0, fail_addr}, {28'd0, e1.addr});
                    check("fail_phase",  {31'd0, fail_phase}, {31'd0, e1.phase});
                    check("fail_cnt",    {28'd0, fail_cnt}, {28'd0, e1.cnt});
                    check("busy_in_done", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    // Monitor for the CW=2 instance
    always @(negedge clk) begin
        if (!rst && done2) begin
            if (done_q2.size() == 0) begin
                check("done2_expected", done_q2.size(), 32'd1);
            end else begin
                e2 = done_q2.pop_front();
                check("done2_cycle",  cyc, e2.cyc);
                check("pass2",        {31'd0, pass2}, {31'd0, e2.pass});
                check("fail_addr2",   {28'd0, fail_addr2}, {28'd0, e2.addr});
                check("fail_phase2",  {31'd0, fail_phase2}, {31'd0, e2.phase});
                check("fail_cnt2",    {30'd0, fail_cnt2}, {28'd0, e2.cnt});
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Pulse start for one cycle; optionally push the expected completion record.
    task automatic start_test(input logic [3:0] s, input bit push, input logic ep,
                              input logic [3:0] ea, input logic eph, input logic [3:0] ec,
                              output int c);
        exp_t e;
        @(negedge clk);
        c = cyc;
        e = '{c + 19, ep, ea, eph, ec};
        if (push) done_q.push_back(e);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        seed  = '0;
    endtask

    int c;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem_rd_data = '0;
        rst = 1'b1; start = 1'b0; seed = '0; start2 = 1'b0; seed2 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {6'd0, busy, done, pass, fail_addr, fail_phase, fail_cnt, mem_wr,
              mem_wr_addr, mem_wr_data, mem_rd, mem_rd_addr}, 32'd0);
        check("rst_outputs2", {busy2, done2, pass2, fail_cnt2, mem_wr2, mem_rd2}, 32'd0);
        rst = 1'b0;

        // Test 1: ideal memory, seed 5
        wr_q = '{8'h05, 8'h14, 8'h27, 8'h36, 8'h0A, 8'h1B, 8'h28, 8'h39};
        fault_mode = 0;
        start_test(4'h5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, c);
        check("t1_first_write", {31'd0, mem_wr}, 32'd1);
        wait_until(c + 24);
        check("t1_done_seen", done_q.size(), 32'd0);
        check("t1_writes_seen", wr_q.size(), 32'd0);
        check("t1_pass_hold", {31'd0, pass}, 32'd1);

        // Test 2: addr 2 bit0 stuck-at-1; only the phase-1 read of 8 fails
        fault_mode = 1;
        start_test(4'h5, 1'b1, 1'b0, 4'd2, 1'b1, 4'd1, c);
        wait_until(c + 6);
        check("t2_pass_low_busy", {31'd0, pass}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd1);
        wait_until(c + 24);
        check("t2_done_seen", done_q.size(), 32'd0);
        check("t2_cnt_hold", {28'd0, fail_cnt}, 32'd1);

        // Test 3: bit7 set at addr 0 fails in both phases
        fault_mode = 2;
        start_test(4'h0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2, c);
        wait_until(c + 24);
        check("t3_done_seen", done_q.size(), 32'd0);

        // Test 4: starts while busy and in DONE are ignored
        fault_mode = 0;
        start_test(4'h5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, c);
        wait_until(c + 3);
        start = 1'b1; seed = 4'hF;
        @(negedge clk);
        start = 1'b0; seed = '0;
        check("t4_busy_after_ignored", {31'd0, busy}, 32'd1);
        wait_until(c + 19);
        start = 1'b1; seed = 4'hF;
        @(negedge clk);
        start = 1'b0; seed = '0;
        check("t4_idle_after_done", {30'd0, busy, done}, 32'd0);
        wait_until(c + 40);
        check("t4_done_seen", done_q.size(), 32'd0);
        check("t4_pass_hold", {31'd0, pass}, 32'd1);

        // Test 5: reset during phase-1 READ, then a fresh full run
        start_test(4'h6, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, c);
        wait_until(c + 15);
        check("t5_in_read", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_outputs", {6'd0, busy, done, pass, fail_addr, fail_phase, fail_cnt, mem_wr,
              mem_wr_addr, mem_wr_data, mem_rd, mem_rd_addr}, 32'd0);
        rst = 1'b0;
        start_test(4'h3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, c);
        wait_until(c + 24);
        check("t5_done_seen", done_q.size(), 32'd0);

        // Test 6: CW=2 instance, all reads 8'hFF, counter saturates at 3
        @(negedge clk);
        c = cyc;
        e2 = '{c + 19, 1'b0, 4'd0, 1'b0, 4'd3};
        done_q2.push_back(e2);
        start2 = 1'b1; seed2 = 4'h0;
        @(negedge clk);
        start2 = 1'b0;
        wait_until(c + 24);
        check("t6_done_seen", done_q2.size(), 32'd0);
        check("t6_cnt_hold", {30'd0, fail_cnt2}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
